// File: rtl/dac_update_sequencer.sv
// dac_update_sequencer: per-channel DAC shadow codes with round-robin dispatch of dirty channels to the SPI controller.
// Optional DAC_REFRESH_EN: a free-running counter periodically marks every channel dirty to recover from DAC upsets.
module dac_update_sequencer #(
    parameter int spi_slaves     = 2,
    parameter int spi_length     = 16,
    parameter int timeout_cycles = 4096,
    parameter int gap_cycles     = 4
`ifdef DAC_REFRESH_EN
    ,
    parameter int refresh_cycles = 1000000
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [$clog2(spi_slaves)-1:0]    wr_addr,
    input  logic [spi_length-1:0]            wr_data,
    output logic [spi_slaves-1:0]            spi_new_reg,
    output logic [spi_slaves*spi_length-1:0] spi_data,
    input  logic                             spi_bLDAC,
    output logic [spi_slaves-1:0]            pending,
    output logic                             busy,
    output logic                             done_pulse,
    output logic                             timeout_err
);
    localparam int AW = $clog2(spi_slaves);
    localparam int TW = $clog2(timeout_cycles + 1);
    localparam int GL = gap_cycles > 0 ? gap_cycles : 1;
    localparam int GW = GL > 1 ? $clog2(GL) : 1;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_GAP} state_t;
    state_t                state;
    logic [AW-1:0]         cur, rr, sel, nxt_rr;
    logic [AW:0]           sum;
    logic [spi_slaves-1:0] rot;
    logic                  sel_v, active, wr_ok, wr_hit, ldac_done, tmo;
    logic [TW-1:0]         tcnt;
    logic [GW-1:0]         gcnt;
    logic                  stage_v;
    logic [spi_length-1:0] stage_d;
`ifdef DAC_REFRESH_EN
    localparam int RW = refresh_cycles > 1 ? $clog2(refresh_cycles) : 1;
    logic [RW-1:0] rcnt;
`endif
    // Rotate pending so bit 0 is the rr pointer; the lowest set bit is the next channel.
    always_comb begin
        rot = spi_slaves'({pending, pending} >> rr);
        sum = {1'b0, rr};
        sel_v = 1'b0;
        for (int i = spi_slaves - 1; i >= 0; i--)
            if (rot[i]) begin
                sum = {1'b0, rr} + (AW + 1)'(i);
                sel_v = 1'b1;
            end
    end
    assign sel       = sum >= (AW + 1)'(spi_slaves) ? AW'(sum - (AW + 1)'(spi_slaves)) : sum[AW-1:0];
    assign nxt_rr    = cur == AW'(spi_slaves - 1) ? '0 : cur + 1'b1;
    assign active    = state == S_ISSUE || state == S_WAIT_LOW || state == S_WAIT_HIGH;
    assign wr_ok     = wr_en && ({1'b0, wr_addr} < (AW + 1)'(spi_slaves));
    assign wr_hit    = wr_ok && active && wr_addr == cur;
    assign ldac_done = state == S_WAIT_HIGH && spi_bLDAC;
    assign tmo       = tcnt >= TW'(timeout_cycles);
    assign busy      = state != S_IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur         <= '0;
            rr          <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            stage_v     <= 1'b0;
            stage_d     <= '0;
            spi_new_reg <= '0;
            spi_data    <= '0;
            pending     <= '0;
            done_pulse  <= 1'b0;
            timeout_err <= 1'b0;
`ifdef DAC_REFRESH_EN
            rcnt        <= '0;
`endif
        end else begin
            spi_new_reg <= '0;
            done_pulse  <= 1'b0;
            if (wr_en)
                timeout_err <= 1'b0;
            if (wr_ok && !wr_hit)
                spi_data[wr_addr*spi_length +: spi_length] <= wr_data;
            // The channel on the wire keeps its code; a write to it waits here until the transfer ends.
            if (wr_hit) begin
                stage_v <= 1'b1;
                stage_d <= wr_data;
            end
            case (state)
                S_IDLE: if (sel_v) begin
                    cur         <= sel;
                    spi_new_reg <= spi_slaves'(1) << sel;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    pending[cur] <= 1'b0;
                    tcnt         <= TW'(1);
                    state        <= S_WAIT_LOW;
                end
                S_WAIT_LOW, S_WAIT_HIGH: begin
                    tcnt <= tcnt + 1'b1;
                    if (ldac_done || tmo) begin
                        rr      <= nxt_rr;
                        gcnt    <= '0;
                        state   <= S_GAP;
                        stage_v <= 1'b0;
                        if (wr_hit || stage_v)
                            spi_data[cur*spi_length +: spi_length] <= wr_hit ? wr_data : stage_d;
                        if (ldac_done)
                            done_pulse <= 1'b1;
                        else begin
                            timeout_err  <= 1'b1;
                            pending[cur] <= 1'b1;
                        end
                    end else if (state == S_WAIT_LOW && !spi_bLDAC)
                        state <= S_WAIT_HIGH;
                end
                S_GAP: begin
                    gcnt <= gcnt + 1'b1;
                    if (gcnt == GW'(GL - 1))
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (wr_ok)
                pending[wr_addr] <= 1'b1;
`ifdef DAC_REFRESH_EN
            rcnt <= rcnt == RW'(refresh_cycles - 1) ? '0 : rcnt + 1'b1;
            if (rcnt == RW'(refresh_cycles - 1))
                pending <= '1;
`endif
        end
    end
endmodule

// File: tb/tb_dac_update_sequencer.sv
// tb_dac_update_sequencer: directed checks of write latency, round-robin order, staging, timeout and async reset.
module tb_dac_update_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [0:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  spi_new_reg;
    logic [31:0] spi_data;
    logic        spi_bLDAC;
    logic [1:0]  pending;
    logic        busy;
    logic        done_pulse;
    logic        timeout_err;
    int nvec = 0;
    int nerr = 0;
    int npulse = 0;
    int p0;

    dac_update_sequencer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .spi_new_reg(spi_new_reg), .spi_data(spi_data), .spi_bLDAC(spi_bLDAC),
        .pending(pending), .busy(busy), .done_pulse(done_pulse), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (|spi_new_reg) npulse++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [0:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic ldac(input int lo);
        spi_bLDAC = 1'b0;
        repeat (lo) tick();
        spi_bLDAC = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; spi_bLDAC = 1'b1;
        repeat (3) tick();
        chk("rst new_reg", 32'(spi_new_reg), 0);
        chk("rst data", spi_data, 0);
        chk("rst pending", 32'(pending), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done_pulse), 0);
        chk("rst tmo", 32'(timeout_err), 0);
        rst_n = 1'b1;
        tick();
        // single write, full handshake
        wr(0, 16'h1234);
        chk("t1 pend n+1", 32'(pending), 32'h1);
        chk("t1 data", spi_data, 32'h0000_1234);
        chk("t1 no early pulse", 32'(spi_new_reg), 0);
        tick();
        chk("t1 pulse n+2", 32'(spi_new_reg), 32'h1);
        chk("t1 busy", 32'(busy), 1);
        tick();
        chk("t1 pulse 1cyc", 32'(spi_new_reg), 0);
        chk("t1 pend clr", 32'(pending), 0);
        ldac(10);
        chk("t1 done", 32'(done_pulse), 1);
        tick();
        chk("t1 done 1cyc", 32'(done_pulse), 0);
        tick(); tick();
        chk("t1 gap busy", 32'(busy), 1);
        tick();
        chk("t1 idle", 32'(busy), 0);
        // reset during WAIT_LOW
        wr(1, 16'h5678);
        tick();
        chk("t2 pulse", 32'(spi_new_reg), 32'h2);
        spi_bLDAC = 1'b0;
        tick();
        chk("t2 busy", 32'(busy), 1);
        chk("t2 data", spi_data, 32'h5678_1234);
        #2 rst_n = 1'b0;
        #1;
        chk("t2 async data", spi_data, 0);
        chk("t2 async busy", 32'(busy), 0);
        chk("t2 async pend", 32'(pending), 0);
        spi_bLDAC = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t2 idle after", 32'(busy), 0);
        // burst ch0 then ch1, rr=0
        p0 = npulse;
        wr(0, 16'h1111);
        wr(1, 16'h2222);
        chk("t3 first ch0", 32'(spi_new_reg), 32'h1);
        chk("t3 both pend", 32'(pending), 32'h3);
        ldac(3);
        chk("t3 done0", 32'(done_pulse), 1);
        repeat (4) tick();
        chk("t3 gap no pulse", 32'(spi_new_reg), 0);
        chk("t3 idle between", 32'(busy), 0);
        tick();
        chk("t3 second ch1", 32'(spi_new_reg), 32'h2);
        ldac(3);
        repeat (6) tick();
        chk("t3 pulse count", 32'(npulse - p0), 2);
        chk("t3 pend empty", 32'(pending), 0);
        chk("t3 data", spi_data, 32'h2222_1111);
        // write to active channel during WAIT_HIGH; rr favours ch1 afterwards
        wr(0, 16'h3333);
        tick();
        chk("t4 pulse ch0", 32'(spi_new_reg), 32'h1);
        spi_bLDAC = 1'b0;
        tick(); tick();
        wr(0, 16'hAAAA);
        wr(1, 16'h4444);
        chk("t4 frozen", spi_data, 32'h4444_3333);
        chk("t4 pend", 32'(pending), 32'h3);
        spi_bLDAC = 1'b1;
        tick();
        chk("t4 done", 32'(done_pulse), 1);
        chk("t4 applied", spi_data, 32'h4444_AAAA);
        repeat (5) tick();
        chk("t4 rr ch1", 32'(spi_new_reg), 32'h2);
        ldac(3);
        repeat (5) tick();
        chk("t4 retx ch0", 32'(spi_new_reg), 32'h1);
        ldac(3);
        repeat (5) tick();
        chk("t4 idle", 32'(busy), 0);
        // timeout with LDAC stuck high
        wr(1, 16'h0F0F);
        tick();
        chk("t5 pulse", 32'(spi_new_reg), 32'h2);
        repeat (4095) tick();
        chk("t5 no tmo yet", 32'(timeout_err), 0);
        tick();
        chk("t5 edge no tmo", 32'(timeout_err), 0);
        chk("t5 waiting", 32'(busy), 1);
        tick();
        chk("t5 tmo", 32'(timeout_err), 1);
        chk("t5 repend", 32'(pending), 32'h2);
        chk("t5 no done", 32'(done_pulse), 0);
        repeat (5) tick();
        chk("t5 retry", 32'(spi_new_reg), 32'h2);
        tick();
        chk("t5 retry clr", 32'(pending), 0);
        ldac(3);
        chk("t5 retry done", 32'(done_pulse), 1);
        chk("t5 sticky", 32'(timeout_err), 1);
        repeat (5) tick();
        // write clears timeout_err; write to cur in the ISSUE cycle is staged
        wr(0, 16'h5555);
        chk("t6 tmo clr", 32'(timeout_err), 0);
        tick();
        chk("t6 pulse", 32'(spi_new_reg), 32'h1);
        wr(0, 16'h6666);
        chk("t6 pend kept", 32'(pending), 32'h1);
        chk("t6 frozen", spi_data, 32'h0F0F_5555);
        ldac(3);
        chk("t6 done", 32'(done_pulse), 1);
        chk("t6 applied", spi_data, 32'h0F0F_6666);
        repeat (5) tick();
        chk("t6 retx", 32'(spi_new_reg), 32'h1);
        ldac(3);
        repeat (5) tick();
        chk("t6 idle", 32'(busy), 0);
        chk("t6 pend empty", 32'(pending), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
